// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH iterations,
// then a one-cycle done pulse with the full 2*WIDTH-bit product.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;

    // The carry out of the upper-half add becomes the MSB after the shift.
    assign addend    = mplier_q[0] ? mcand_q : '0;
    assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign acc_shift = {sum, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_shift;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = acc_shift;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and swept checks of seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, busy16, done16;
    logic [15:0] prod8;
    logic [31:0] prod16;

    int total;
    int bad;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full 8-bit operation with timing checks: busy for 8 cycles, done for 1.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                        input string nm);
        @(negedge clk);
        a8 = ta; b8 = tb; start8 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) start8 = 1'b0;
            total++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                bad++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0", nm, i, busy8, done8);
            end
            @(posedge clk);
        end
        @(negedge clk);
        total++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL %s done cycle: done=%b busy=%b, want done=1 busy=0", nm, done8, busy8);
        end
        total++;
        if (prod8 !== exp) begin
            bad++;
            $display("FAIL %s product: got %0d, want %0d", nm, prod8, exp);
        end
        @(negedge clk);
        total++;
        if (done8 !== 1'b0) begin
            bad++;
            $display("FAIL %s done width: done=%b one cycle later, want 0", nm, done8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL reset flags: busy=%b done=%b, want 0 0", busy8, done8);
        end
        total++;
        if (prod8 !== 16'd0 || prod16 !== 32'd0) begin
            bad++;
            $display("FAIL reset product: got %0d/%0d, want 0/0", prod8, prod16);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run8(8'd3, 8'd5, 16'd15, "basic_3x5");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (prod8 !== 16'd15 || busy8 !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold: product=%0d busy=%b, want 15 0", prod8, busy8);
            end
        end
    endtask

    task automatic test_boundaries();
        run8(8'd255, 8'd255, 16'd65025, "max_x_max");
        run8(8'd0, 8'd200, 16'd0, "zero_x_200");
        run8(8'd200, 8'd0, 16'd0, "200_x_zero");
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [15:0] seen;
        ndone = 0;
        seen  = '0;
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk); start8 = 1'b0; a8 = 8'd200; b8 = 8'd77;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                ndone++;
                seen = prod8;
            end
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL ignore_start pulses: got %0d done pulses, want 1", ndone);
        end
        total++;
        if (seen !== 16'd63 || prod8 !== 16'd63) begin
            bad++;
            $display("FAIL ignore_start product: got %0d (final %0d), want 63", seen, prod8);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd10; start8 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            exp_done = ((c % 9) == 0);
            total++;
            if (done8 !== exp_done || busy8 !== !exp_done) begin
                bad++;
                $display("FAIL b2b cycle %0d: done=%b busy=%b, want done=%b busy=%b",
                         c, done8, busy8, exp_done, !exp_done);
            end
            if (exp_done) begin
                total++;
                if (prod8 !== 16'd120) begin
                    bad++;
                    $display("FAIL b2b product cycle %0d: got %0d, want 120", c, prod8);
                end
            end
            if (c == 27) start8 = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        total++;
        if (busy8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b stop: busy=%b after start dropped, want 0", busy8);
        end
    endtask

    task automatic test_async_reset();
        int ndone;
        ndone = 0;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset flags: busy=%b done=%b, want 0 0", busy8, done8);
        end
        total++;
        if (prod8 !== 16'd0) begin
            bad++;
            $display("FAIL async_reset product: got %0d, want 0", prod8);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL async_reset aftermath: %0d active cycles after abort, want 0", ndone);
        end
        run8(8'd2, 8'd3, 16'd6, "after_reset_2x3");
    endtask

    task automatic test_start_at_reset_release();
        int nbusy;
        nbusy = 0;
        @(negedge clk);
        rst = 1'b1; a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy8 === 1'b1 || done8 === 1'b1) nbusy++;
        end
        total++;
        if (nbusy != 0) begin
            bad++;
            $display("FAIL reset_release_start: %0d active cycles, want 0", nbusy);
        end
    endtask

    task automatic test_sweep(input bit wide, input int n);
        logic [15:0] ta, tb;
        logic [31:0] exp, got_p;
        int          lat, want_lat;
        bit          got;
        want_lat = wide ? 17 : 9;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                ta = wide ? 16'hFFFF : 16'h00FF;
                tb = ta;
            end else if (k == 1) begin
                ta = '0;
                tb = wide ? 16'(($urandom_range(1, 65535))) : 16'(($urandom_range(1, 255)));
            end else if (wide) begin
                ta = 16'($urandom_range(0, 65535));
                tb = 16'($urandom_range(0, 65535));
            end else begin
                ta = 16'($urandom_range(0, 255));
                tb = 16'($urandom_range(0, 255));
            end
            exp = 32'(ta) * 32'(tb);
            @(negedge clk);
            if (wide) begin
                a16 = ta; b16 = tb; start16 = 1'b1;
            end else begin
                a8 = ta[7:0]; b8 = tb[7:0]; start8 = 1'b1;
            end
            @(posedge clk);
            lat = 1;
            got = 1'b0;
            while (!got && lat < 40) begin
                @(negedge clk);
                start8 = 1'b0; start16 = 1'b0;
                if ((wide ? done16 : done8) === 1'b1) got = 1'b1;
                else begin
                    @(posedge clk);
                    lat++;
                end
            end
            got_p = wide ? prod16 : {16'd0, prod8};
            total++;
            if (!got) begin
                bad++;
                $display("FAIL sweep w%0d timeout: %0dx%0d no done within 40 edges", wide ? 16 : 8, ta, tb);
            end else begin
                if (lat != want_lat) begin
                    bad++;
                    $display("FAIL sweep w%0d latency %0dx%0d: got %0d edges, want %0d",
                             wide ? 16 : 8, ta, tb, lat, want_lat);
                end
                total++;
                if (got_p !== exp) begin
                    bad++;
                    $display("FAIL sweep w%0d product %0dx%0d: got %0d, want %0d",
                             wide ? 16 : 8, ta, tb, got_p, exp);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_start_at_reset_release();
        test_sweep(1'b0, 200);
        test_sweep(1'b1, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
